// File: rtl/ins_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Kept in one place so the instruction memory and the loader agree on depth/width.
package ins_mem_loader_pkg;

  localparam int DEF_NUM_WORDS = 16;
  localparam int DEF_ADDR_W    = 4;
  localparam int LEN_W         = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ins_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words and tracks the byte position.
// o_last is high while the next accepted byte completes the current word.
module ins_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_last
);

  logic [31:0] r_word;
  logic [1:0]  r_byte_cnt;

  // The first byte ends up in [31:24] after four shifts, so no position mux is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
    end else if (i_clear) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
    end else if (i_shift) begin
      r_word     <= {r_word[23:0], i_byte};
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  assign o_word = r_word;
  assign o_last = (r_byte_cnt == 2'd3);

endmodule

// File: rtl/ins_mem_loader.sv
// Loads a byte stream into instruction memory as 32-bit words starting at address 0.
// The session length is clamped to the memory depth; abort discards any partial word.
module ins_mem_loader
  import ins_mem_loader_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len_words,
  input  logic              i_abort,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_done
);

  // One extra bit so the count can reach NUM_WORDS without wrapping the address.
  localparam int CNT_W = ADDR_W + 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [LEN_W-1:0] w_len_clamped;
  logic             w_accept_start;
  logic             w_clear;
  logic             w_shift;
  logic             w_last;
  logic [31:0]      w_word;

  assign w_accept_start = (r_state == S_IDLE) && i_start;
  assign w_cnt_inc      = r_word_cnt + CNT_W'(1);
  assign w_len_clamped  = (i_len_words > LEN_W'(NUM_WORDS)) ? LEN_W'(NUM_WORDS) : i_len_words;
  assign w_shift        = o_byte_ready && i_byte_valid;

  ins_word_assembler u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_shift (w_shift),
    .i_byte  (i_byte_data),
    .o_word  (w_word),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
      r_len      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept_start) begin
        r_word_cnt <= '0;
        r_len      <= CNT_W'(w_len_clamped);
      end else if ((r_state == S_WRITE) && !i_abort) begin
        r_word_cnt <= w_cnt_inc;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_byte_ready = 1'b0;
    o_wr_en      = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_clear      = 1'b1;
          w_state_next = (i_len_words == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        o_busy       = 1'b1;
        o_byte_ready = 1'b1;
        if (i_abort) begin
          w_clear      = 1'b1;
          w_state_next = S_IDLE;
        end else if (i_byte_valid && w_last) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        o_busy = 1'b1;
        // Abort wins over the pending write: the strobe is suppressed this cycle.
        if (i_abort) begin
          w_clear      = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          o_wr_en      = 1'b1;
          w_state_next = (w_cnt_inc == r_len) ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_wr_addr = r_word_cnt[ADDR_W-1:0];
  assign o_wr_data = w_word;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Self-checking bench for ins_mem_loader: directed scenarios plus randomized sessions
// checked against a byte-stream/word-list model of what a session should write.
module tb_ins_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [4:0]  i_len_words;
  logic        i_abort;
  logic        i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready;
  logic        o_wr_en;
  logic [3:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_busy;
  logic        o_done;

  int tests = 0;
  int fails = 0;
  logic [7:0] bytes_q[$];

  always #5 clk = ~clk;

  ins_mem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_len_words  (i_len_words),
    .i_abort      (i_abort),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .o_byte_ready (o_byte_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One load session. Expected writes are the byte stream cut into big-endian words;
  // a word is written in the cycle after its fourth accepted byte. abort_at >= 0 raises
  // abort on the first cycle where that many bytes have been accepted.
  task automatic run_session(input int len, input int vprob, input bit toggle, input int abort_at);
    int eff, nbytes, nwords, cyc;
    bit pending, abort_now, fin;
    logic [31:0] exp_word;
    eff = (len > 16) ? 16 : len;
    for (int i = bytes_q.size(); i < eff * 4; i++) bytes_q.push_back(8'($urandom));
    $display("[TB] session len=%0d eff=%0d vprob=%0d toggle=%0d abort_at=%0d", len, eff, vprob, toggle, abort_at);
    step();
    i_start = 1'b1; i_len_words = 5'(len); i_abort = 1'b0; i_byte_valid = 1'b0;
    @(negedge clk);
    chk("idle_busy_before_start", o_busy, 1'b0);
    step();
    i_start = 1'b0;
    if (eff == 0) begin
      @(negedge clk);
      chk("zero_len_done", o_done, 1'b1);
      chk("zero_len_busy", o_busy, 1'b0);
      chk("zero_len_wr_en", o_wr_en, 1'b0);
      step();
      @(negedge clk);
      chk("zero_len_done_drop", o_done, 1'b0);
      chk("zero_len_busy_after", o_busy, 1'b0);
      bytes_q.delete();
      return;
    end
    nbytes = 0; nwords = 0; cyc = 0; pending = 1'b0; fin = 1'b0;
    while (!fin) begin
      abort_now    = (abort_at >= 0) && (nbytes == abort_at);
      i_abort      = abort_now;
      i_start      = ($urandom_range(0, 7) == 0);
      i_len_words  = 5'($urandom);
      i_byte_valid = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 99) < vprob);
      i_byte_data  = (nbytes < bytes_q.size()) ? bytes_q[nbytes] : 8'($urandom);
      @(negedge clk);
      chk("busy_in_session", o_busy, 1'b1);
      chk("done_in_session", o_done, 1'b0);
      if (pending) begin
        exp_word = {bytes_q[4*nwords], bytes_q[4*nwords+1], bytes_q[4*nwords+2], bytes_q[4*nwords+3]};
        chk("byte_ready_in_write", o_byte_ready, 1'b0);
        chk("wr_en_in_write", o_wr_en, abort_now ? 1'b0 : 1'b1);
        if (!abort_now) begin
          chk("wr_addr", o_wr_addr, 32'(nwords));
          chk("wr_data", o_wr_data, exp_word);
          $display("[TB] write addr=%0d data=%08h expected=%08h", o_wr_addr, o_wr_data, exp_word);
          nwords++;
          pending = 1'b0;
        end
      end else begin
        chk("byte_ready_in_load", o_byte_ready, 1'b1);
        chk("wr_en_in_load", o_wr_en, 1'b0);
        if (i_byte_valid && !abort_now) begin
          nbytes++;
          if (nbytes % 4 == 0) pending = 1'b1;
        end
      end
      cyc++;
      step();
      if (abort_now) begin
        i_abort = 1'b0; i_start = 1'b0; i_byte_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_byte_ready", o_byte_ready, 1'b0);
        chk("abort_done", o_done, 1'b0);
        chk("abort_wr_en", o_wr_en, 1'b0);
        $display("[TB] aborted after %0d bytes, %0d words written", nbytes, nwords);
        fin = 1'b1;
      end else if (!pending && nwords == eff) begin
        i_start = 1'b0; i_byte_valid = 1'($urandom);
        @(negedge clk);
        chk("done_pulse", o_done, 1'b1);
        chk("done_busy", o_busy, 1'b0);
        chk("done_wr_en", o_wr_en, 1'b0);
        chk("done_byte_ready", o_byte_ready, 1'b0);
        step();
        @(negedge clk);
        chk("done_drop", o_done, 1'b0);
        chk("idle_busy", o_busy, 1'b0);
        $display("[TB] session complete, %0d words written", nwords);
        fin = 1'b1;
      end else if (cyc > 4000) begin
        chk("session_timeout_words", 32'(nwords), 32'(eff));
        fin = 1'b1;
      end
    end
    i_start = 1'b0; i_abort = 1'b0; i_byte_valid = 1'b0;
    bytes_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int eff, ab;
    rst_n = 1'b0; i_start = 1'b0; i_len_words = '0; i_abort = 1'b0;
    i_byte_valid = 1'b0; i_byte_data = '0;
    #12;
    chk("rst_byte_ready", o_byte_ready, 1'b0);
    chk("rst_wr_en", o_wr_en, 1'b0);
    chk("rst_wr_addr", o_wr_addr, 4'd0);
    chk("rst_wr_data", o_wr_data, 32'd0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two words, continuous stream.
    bytes_q = '{8'h41, 8'h1F, 8'h00, 8'h00, 8'h42, 8'h2F, 8'h00, 8'h01};
    run_session(2, 100, 1'b0, -1);
    // Toggling byte_valid, single word.
    bytes_q = '{8'h41, 8'h1F, 8'h00, 8'h00};
    run_session(1, 0, 1'b1, -1);
    // Over-length request clamps to full depth.
    run_session(20, 100, 1'b0, -1);
    // Zero-length session.
    run_session(0, 100, 1'b0, -1);
    // Abort two bytes into the second word, then a fresh session from address 0.
    run_session(2, 100, 1'b0, 6);
    run_session(1, 100, 1'b0, -1);
    // Abort exactly in the write cycle of the first word.
    run_session(3, 100, 1'b0, 4);

    for (int s = 0; s < 12; s++) begin
      int len;
      len = $urandom_range(0, 20);
      eff = (len > 16) ? 16 : len;
      ab  = ($urandom_range(0, 3) == 0 && eff > 0) ? $urandom_range(0, eff * 4) : -1;
      run_session(len, $urandom_range(30, 100), 1'b0, ab);
    end

    // Reset while a write is pending.
    step();
    i_start = 1'b1; i_len_words = 5'd1;
    step();
    i_start = 1'b0; i_byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_byte_data = 8'(8'hA0 + i);
      step();
    end
    i_byte_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_wr_en", o_wr_en, 1'b1);
    chk("pre_reset_wr_data", o_wr_data, 32'hA0A1A2A3);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_wr_en", o_wr_en, 1'b0);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_byte_ready", o_byte_ready, 1'b0);
    chk("reset_wr_addr", o_wr_addr, 4'd0);
    chk("reset_wr_data", o_wr_data, 32'd0);
    chk("reset_done", o_done, 1'b0);
    $display("[TB] reset asserted during write");
    #1 rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("post_reset_wr_en", o_wr_en, 1'b0);
    chk("post_reset_busy", o_busy, 1'b0);
    run_session(1, 100, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
